rom_stream_scheduler: RTL
=========================

# rom_stream_scheduler

Sequencer and two-way arbiter for the `serial_data_converter` datapath. Two requesters each want a run of consecutive 96-bit ROM words serialized, for example the board-graphics path and the status-text path. This block:
- grants one requester at a time, round-robin;
- fetches the requested ROM words through a one-word prefetch register;
- hands each word to the converter exactly once per `ready_read` assertion.

## Interface
- `ROM_DATA_WIDTH`, 96: ROM word width; equals the converter's `ROM_DATA_WIDTH`.
- `ROM_ADDR_WIDTH`, 6: ROM address width.
- `LEN_WIDTH`, 6: width of the word-count fields.
- `clk_i`  in  1  the single clock; all state changes on its rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `req_i`  in  2  request level per requester; bit 0 is requester 0.
- `req_addr0_i`, `req_addr1_i`  in  ROM_ADDR_WIDTH  start address per requester.
- `req_len0_i`, `req_len1_i`  in  LEN_WIDTH  word count per requester.
- `grant_o`  out  2  one-hot; high for the whole job of the granted requester.
- `done_o`  out  2  one-cycle pulse when the granted job completes.
- `busy_o`  out  1  high whenever state is not IDLE.
- `rom_en_o`  out  1  ROM read strobe.
- `rom_addr_o`  out  ROM_ADDR_WIDTH  ROM read address.
- `rom_q_i`  in  ROM_DATA_WIDTH  ROM read data, valid exactly one cycle after `rom_en_o`.
- `ready_read_i`  in  1  the converter's `ready_read_o`.
- `rom_data_o`  out  ROM_DATA_WIDTH  word driven to the converter's `rom_data_i`.
- `data_valid_o`  out  1  high while `rom_data_o` holds a word of the current job.
- `underrun_o`  out  1  sticky; a ready edge arrived with the prefetch register empty.

## Operation
- All outputs are registered.
- Reset values:
  - `grant_o`, `done_o`, `busy_o`, `rom_en_o`, `data_valid_o`, `underrun_o`: 0.
  - `rom_addr_o`, `rom_data_o`: 0.
  - State is IDLE; round-robin pointer `last_q` is 1, so requester 0 wins the first tie.
  - Ready edge register `rr_q` is 0; prefetch register is empty.
- Ready edge = `ready_read_i` high and `rr_q` low. `rr_q` samples `ready_read_i` every cycle, in every state. A level held high counts as one edge only.
- **IDLE**:
  - If any `req_i` bit is set, grant the requester not equal to `last_q` if it requests, otherwise the one that requests.
  - On grant: latch its address into `addr_q` and its length into `rem_q`, set `grant_o`, update `last_q`.
  - If the latched length is 0, go to FINISH. Otherwise go to FETCH.
- **FETCH** (one cycle): `rom_en_o`=1 and `rom_addr_o`=`addr_q`. Then `addr_q` increments (wraps modulo 2^ROM_ADDR_WIDTH) and `rem_q` decrements. Go to WAIT.
- **WAIT** (one cycle): capture `rom_q_i` into the prefetch register, set it full, go to STREAM.
- **STREAM**, on a ready edge with prefetch full:
  - `rom_data_o` ← prefetch, `data_valid_o`=1, prefetch goes empty.
  - If `rem_q` > 0, go to FETCH. If `rem_q` = 0, go to DRAIN.
- **STREAM**, on a ready edge with prefetch empty (not reachable with a correct converter): set `underrun_o`, leave `rom_data_o` unchanged.
- **DRAIN**: wait for the next ready edge; it retires the last word. Then `data_valid_o`=0 and go to FINISH.
- **FINISH** (one cycle): pulse `done_o` for the granted bit, clear `grant_o`, go to IDLE.
- Requests and input fields are sampled only at grant. A `req_i` drop mid-job does not abort the job.
- A requester that still requests after its `done_o` is re-arbitrated in IDLE and loses to the other requester if both request.
- `underrun_o` clears only on reset.
- Reset asserted mid-job aborts immediately: all registers return to reset values and no `done_o` pulse is produced.

## Timing
- Grant edge E0 (IDLE with a request):
  - E0+1: `rom_en_o`=1 and `rom_addr_o`=start address, for one cycle.
  - E0+2: prefetch full (read latency is 1).
- Word k (0-based) appears on `rom_data_o` at the clock edge that samples the (k+1)th ready edge of the job. This is zero added latency, because the word comes from the prefetch register.
- Refill of the next word completes 2 cycles after each transfer. A converter period is ROM_DATA_WIDTH/SELECT_SIZE = 32 cycles, so refill never underruns.
- End of a job of length N:
  - `done_o` pulses 1 cycle after the ready edge that retires word N-1 (the (N+1)th ready edge).
  - IDLE is reached the cycle after that, with new arbitration on the following edge.
- Length 0: `grant_o` high for 1 cycle, `done_o` 1 cycle later, no ROM access.
- Ready edges outside STREAM and DRAIN are ignored, and `rr_q` still tracks the input.

## Test plan
- **Single job.** `req_i`=01, addr0=5, len0=3; converter model pulses `ready_read` every 32 cycles.
  - Required: `rom_addr_o` reads 5, 6, 7 in order.
  - Required: `rom_data_o` shows ROM[5], ROM[6], ROM[7], one per ready edge.
  - Required: one `done_o[0]` pulse one cycle after the 4th edge; `underrun_o`=0.
- **Simultaneous requests.** `req_i`=11, len0=len1=2, both held high.
  - Required grant order: 0, 1, 0, 1.
  - Required: `grant_o` never 11; `done_o` alternates.
- **Zero length.** `req_i`=10, len1=0.
  - Required: `grant_o`=10 for 1 cycle, then `done_o`=10; `rom_en_o` never asserted.
- **Address wrap.** addr0=63, len0=2.
  - Required: reads at addresses 63 then 0.
- **Held ready level.** `ready_read_i` held high for 5 cycles.
  - Required: exactly one word transfer.
- **Reset mid-job.** `rst_ni` low for 1 cycle after the 2nd word of a 4-word job.
  - Required: all outputs 0 asynchronously and no `done_o` pulse.
  - Required: a new request after release restarts from its start address.

Source files
------------

// File: rtl/rom_stream_scheduler.sv
// Round-robin sequencer that streams runs of ROM words into the serial converter,
// one word per ready edge, through a single-entry prefetch register.
module rom_stream_scheduler #(
  parameter int ROM_DATA_WIDTH = 96,
  parameter int ROM_ADDR_WIDTH = 6,
  parameter int LEN_WIDTH      = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_i,
  input  logic [ROM_ADDR_WIDTH-1:0] req_addr0_i,
  input  logic [ROM_ADDR_WIDTH-1:0] req_addr1_i,
  input  logic [LEN_WIDTH-1:0]      req_len0_i,
  input  logic [LEN_WIDTH-1:0]      req_len1_i,
  output logic [1:0]                grant_o,
  output logic [1:0]                done_o,
  output logic                      busy_o,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [ROM_DATA_WIDTH-1:0] rom_q_i,
  input  logic                      ready_read_i,
  output logic [ROM_DATA_WIDTH-1:0] rom_data_o,
  output logic                      data_valid_o,
  output logic                      underrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_ONE  = {{(ROM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_ZERO = {ROM_ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]      LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]      LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [ROM_DATA_WIDTH-1:0] DATA_ZERO = {ROM_DATA_WIDTH{1'b0}};

  state_t                      state_r;
  logic                        last_r;
  logic                        gnt_idx_r;
  logic [ROM_ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]        rem_r;
  logic [ROM_DATA_WIDTH-1:0]   pf_r;
  logic                        pf_full_r;
  logic                        rr_r;

  logic                        ready_edge_s;
  logic                        winner_s;
  logic [ROM_ADDR_WIDTH-1:0]   start_addr_s;
  logic [LEN_WIDTH-1:0]        start_len_s;

  // Ready edge detect and round-robin winner selection (the non-last requester is preferred).
  always_comb begin
    ready_edge_s = ready_read_i & ~rr_r;
    winner_s     = last_r;
    if (last_r == 1'b1) begin
      winner_s = req_i[0] ? 1'b0 : 1'b1;
    end else begin
      winner_s = req_i[1] ? 1'b1 : 1'b0;
    end
    if (winner_s == 1'b1) begin
      start_addr_s = req_addr1_i;
      start_len_s  = req_len1_i;
    end else begin
      start_addr_s = req_addr0_i;
      start_len_s  = req_len0_i;
    end
  end

  // Job sequencer: arbitration, ROM fetch, prefetch hand-off and completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      last_r       <= 1'b1;
      gnt_idx_r    <= 1'b0;
      addr_r       <= ADDR_ZERO;
      rem_r        <= LEN_ZERO;
      pf_r         <= DATA_ZERO;
      pf_full_r    <= 1'b0;
      rr_r         <= 1'b0;
      grant_o      <= 2'b00;
      done_o       <= 2'b00;
      busy_o       <= 1'b0;
      rom_en_o     <= 1'b0;
      rom_addr_o   <= ADDR_ZERO;
      rom_data_o   <= DATA_ZERO;
      data_valid_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      rr_r   <= ready_read_i;
      done_o <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (req_i != 2'b00) begin
            grant_o   <= winner_s ? 2'b10 : 2'b01;
            gnt_idx_r <= winner_s;
            last_r    <= winner_s;
            addr_r    <= start_addr_s;
            rem_r     <= start_len_s;
            busy_o    <= 1'b1;
            if (start_len_s == LEN_ZERO) begin
              state_r <= ST_FINISH;
            end else begin
              // The strobe is launched together with the state change so it is high during FETCH.
              state_r    <= ST_FETCH;
              rom_en_o   <= 1'b1;
              rom_addr_o <= start_addr_s;
            end
          end
        end
        ST_FETCH: begin
          rom_en_o <= 1'b0;
          addr_r   <= addr_r + ADDR_ONE;
          rem_r    <= rem_r - LEN_ONE;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          pf_r      <= rom_q_i;
          pf_full_r <= 1'b1;
          state_r   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (ready_edge_s) begin
            if (pf_full_r) begin
              rom_data_o   <= pf_r;
              data_valid_o <= 1'b1;
              pf_full_r    <= 1'b0;
              if (rem_r != LEN_ZERO) begin
                state_r    <= ST_FETCH;
                rom_en_o   <= 1'b1;
                rom_addr_o <= addr_r;
              end else begin
                state_r <= ST_DRAIN;
              end
            end else begin
              underrun_o <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (ready_edge_s) begin
            data_valid_o <= 1'b0;
            state_r      <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_o  <= gnt_idx_r ? 2'b10 : 2'b01;
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          grant_o  <= 2'b00;
          busy_o   <= 1'b0;
          rom_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
